// File: rtl/fft_addr_gen.sv
// Radix-2 DIT butterfly address sequencer: A/B/twiddle read addresses per butterfly, stage by stage.
// Latency: first addresses one cycle after i_start, o_done ADDR_SIZE*(N/2+PIPE_LATENCY) cycles later.
// Backpressure: none; inter-stage WAIT of PIPE_LATENCY cycles. Optional FFT_AGU_STAGE_IRQ_EN adds o_stage_done.
module fft_addr_gen #(
    parameter int ADDR_SIZE    = 5,
    parameter int PIPE_LATENCY = 3
) (
    input  logic                         i_CLK,
    input  logic                         i_RST_n,
    input  logic                         i_start,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_rd_en,
    output logic [ADDR_SIZE-1:0]         o_rdaddr_A,
    output logic [ADDR_SIZE-1:0]         o_rdaddr_B,
    output logic [ADDR_SIZE-2:0]         o_rdaddr_twiddle,
    output logic                         o_wr_en,
`ifdef FFT_AGU_STAGE_IRQ_EN
    output logic                         o_stage_done,
`endif
    output logic [$clog2(ADDR_SIZE)-1:0] o_stage
);

    localparam int SW = $clog2(ADDR_SIZE);
    localparam int JW = ADDR_SIZE - 1;
    localparam int WW = $clog2(PIPE_LATENCY + 1);

    localparam logic [JW-1:0]        J_LAST   = {JW{1'b1}};
    localparam logic [JW-1:0]        J_ONE    = JW'(1);
    localparam logic [SW-1:0]        S_LAST   = SW'(ADDR_SIZE - 1);
    localparam logic [SW-1:0]        S_ONE    = SW'(1);
    localparam logic [SW:0]          SP1_ONE  = (SW + 1)'(1);
    localparam logic [WW-1:0]        W_LOAD   = WW'(PIPE_LATENCY);
    localparam logic [WW-1:0]        W_ONE    = WW'(1);
    localparam logic [ADDR_SIZE-1:0] A_ONE    = ADDR_SIZE'(1);

    typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  s_q, s_d;
    logic [JW-1:0]  j_q, j_d;
    logic [WW-1:0]  wait_q, wait_d;

    logic                 rd_en_d, busy_d, done_d;
    logic [ADDR_SIZE-1:0] addr_a_d, addr_b_d;
    logic [JW-1:0]        addr_tw_d;

    logic [ADDR_SIZE-1:0] j_ext, span, lo_mask, a_calc, b_calc;
    logic [SW:0]          s_p1;
    logic [JW-1:0]        tw_calc;
    logic [PIPE_LATENCY-1:0] dl_q;

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            j_q     <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            j_q     <= j_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = RUN;
                    s_d     = '0;
                    j_d     = '0;
                end
            end
            RUN: begin
                if (j_q == J_LAST) begin
                    state_d = WAIT;
                    wait_d  = W_LOAD;
                end else begin
                    j_d = j_q + J_ONE;
                end
            end
            WAIT: begin
                if (wait_q == W_ONE) begin
                    if (s_q == S_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        s_d     = s_q + S_ONE;
                        j_d     = '0;
                    end
                end else begin
                    wait_d = wait_q - W_ONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Addresses are computed from the next-state counters so the registered outputs line up with state.
    assign j_ext   = {1'b0, j_d};
    assign span    = A_ONE << s_d;
    assign lo_mask = span - A_ONE;
    assign s_p1    = {1'b0, s_d} + SP1_ONE;
    assign a_calc  = ((j_ext >> s_d) << s_p1) | (j_ext & lo_mask);
    assign b_calc  = a_calc | span;
    assign tw_calc = (j_d & lo_mask[JW-1:0]) << (S_LAST - s_d);

    always_comb begin
        rd_en_d   = (state_d == RUN);
        busy_d    = (state_d == RUN) || (state_d == WAIT);
        done_d    = (state_d == DONE);
        addr_a_d  = o_rdaddr_A;
        addr_b_d  = o_rdaddr_B;
        addr_tw_d = o_rdaddr_twiddle;
        if (rd_en_d) begin
            addr_a_d  = a_calc;
            addr_b_d  = b_calc;
            addr_tw_d = tw_calc;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            o_rd_en          <= 1'b0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_rdaddr_A       <= '0;
            o_rdaddr_B       <= '0;
            o_rdaddr_twiddle <= '0;
            o_stage          <= '0;
        end else begin
            o_rd_en          <= rd_en_d;
            o_busy           <= busy_d;
            o_done           <= done_d;
            o_rdaddr_A       <= addr_a_d;
            o_rdaddr_B       <= addr_b_d;
            o_rdaddr_twiddle <= addr_tw_d;
            o_stage          <= s_d;
        end
    end

`ifdef FFT_AGU_STAGE_IRQ_EN
    logic stage_done_d;
    assign stage_done_d = (state_d == WAIT) && (wait_d == W_ONE);

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) o_stage_done <= 1'b0;
        else          o_stage_done <= stage_done_d;
    end
`endif

    generate
        if (PIPE_LATENCY == 1) begin : g_dl1
            always_ff @(posedge i_CLK or negedge i_RST_n) begin
                if (!i_RST_n) dl_q <= '0;
                else          dl_q <= o_rd_en;
            end
        end else begin : g_dln
            always_ff @(posedge i_CLK or negedge i_RST_n) begin
                if (!i_RST_n) dl_q <= '0;
                else          dl_q <= {dl_q[PIPE_LATENCY-2:0], o_rd_en};
            end
        end
    endgenerate

    assign o_wr_en = dl_q[PIPE_LATENCY-1];

endmodule

// File: tb/tb_fft_addr_gen.sv
// Bench for fft_addr_gen: cycle-level schedule model plus directed literal checks.
`timescale 1ns/1ps
module tb_fft_addr_gen;

    localparam int AW      = 5;
    localparam int PL      = 3;
    localparam int N       = 1 << AW;
    localparam int HALF    = N / 2;
    localparam int STG_LEN = HALF + PL;
    localparam int TOTAL   = AW * STG_LEN;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, rd_en, wr_en;
    logic [AW-1:0] a, b;
    logic [AW-2:0] tw;
    logic [2:0]    stage;
`ifdef FFT_AGU_STAGE_IRQ_EN
    logic          stage_done;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fft_addr_gen #(.ADDR_SIZE(AW), .PIPE_LATENCY(PL)) dut (
        .i_CLK            (clk),
        .i_RST_n          (rst_n),
        .i_start          (start),
        .o_busy           (busy),
        .o_done           (done),
        .o_rd_en          (rd_en),
        .o_rdaddr_A       (a),
        .o_rdaddr_B       (b),
        .o_rdaddr_twiddle (tw),
        .o_wr_en          (wr_en),
`ifdef FFT_AGU_STAGE_IRQ_EN
        .o_stage_done     (stage_done),
`endif
        .o_stage          (stage)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Butterfly j of stage s: insert a zero bit at position s to get the upper leg.
    function automatic void bfly(input int s, input int j, output int ea, output int eb, output int etw);
        int span;
        span = 1 << s;
        ea   = (j / span) * 2 * span + (j % span);
        eb   = ea + span;
        etw  = (j % span) * (N / (2 * span));
    endfunction

    // Model: edges elapsed since the start edge; TOTAL is the DONE cycle.
    bit m_act;
    int m_t;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act <= 1'b0;
            m_t   <= 0;
        end else if (!m_act) begin
            if (start) begin
                m_act <= 1'b1;
                m_t   <= 0;
            end
        end else if (m_t == TOTAL) begin
            m_act <= 1'b0;
        end else begin
            m_t <= m_t + 1;
        end
    end

    int ea, eb, etw;
    int rd_cnt, wr_cnt, irq_cnt;
    int hits [AW][N];

    always @(negedge clk) begin
        int t, s, idx, bad;
        bit e_rd, e_wr, e_busy, e_done, e_irq;
        if (!rst_n) begin
            ea = 0; eb = 0; etw = 0;
        end else begin
            t = m_t;
            e_rd = 0; e_wr = 0; e_busy = 0; e_done = 0; e_irq = 0;
            if (m_act) begin
                if (t == 0) begin
                    rd_cnt = 0; wr_cnt = 0; irq_cnt = 0;
                    for (int i = 0; i < AW; i++)
                        for (int k = 0; k < N; k++) hits[i][k] = 0;
                end
                if (t < TOTAL) begin
                    s      = t / STG_LEN;
                    idx    = t % STG_LEN;
                    e_busy = 1;
                    e_rd   = (idx < HALF);
                    e_irq  = (idx == STG_LEN - 1);
                    if (e_rd) bfly(s, idx, ea, eb, etw);
                    chk("stage", 32'(stage), s);
                    if (rd_en) begin
                        hits[s][a]++;
                        hits[s][b]++;
                    end
                end else begin
                    e_done = 1;
                end
                if (t >= PL && ((t - PL) % STG_LEN) < HALF) e_wr = 1;
                if (rd_en) rd_cnt++;
                if (wr_en) wr_cnt++;
`ifdef FFT_AGU_STAGE_IRQ_EN
                if (stage_done) irq_cnt++;
`endif
            end
            chk("rd_en", 32'(rd_en), 32'(e_rd));
            chk("wr_en", 32'(wr_en), 32'(e_wr));
            chk("busy",  32'(busy),  32'(e_busy));
            chk("done",  32'(done),  32'(e_done));
            chk("addr_A", 32'(a), ea);
            chk("addr_B", 32'(b), eb);
            chk("addr_tw", 32'(tw), etw);
`ifdef FFT_AGU_STAGE_IRQ_EN
            chk("stage_done", 32'(stage_done), 32'(e_irq));
`endif
            if (m_act && t == TOTAL) begin
                chk("rd_total", rd_cnt, AW * HALF);
                chk("wr_total", wr_cnt, AW * HALF);
                bad = 0;
                for (int i = 0; i < AW; i++)
                    for (int k = 0; k < N; k++)
                        if (hits[i][k] != 1) bad++;
                chk("coverage_bad_slots", bad, 0);
`ifdef FFT_AGU_STAGE_IRQ_EN
                chk("stage_done_total", irq_cnt, AW);
`endif
            end
        end
    end

    task automatic wait_done(input int lim, output int n);
        n = 0;
        while (!done && n < lim) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", 32'(done), 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd"},    32'(rd_en), 0);
        chk({tag, "_wr"},    32'(wr_en), 0);
        chk({tag, "_busy"},  32'(busy),  0);
        chk({tag, "_done"},  32'(done),  0);
        chk({tag, "_A"},     32'(a),     0);
        chk({tag, "_B"},     32'(b),     0);
        chk({tag, "_tw"},    32'(tw),    0);
        chk({tag, "_stage"}, 32'(stage), 0);
`ifdef FFT_AGU_STAGE_IRQ_EN
        chk({tag, "_irq"},   32'(stage_done), 0);
`endif
    endtask

    initial begin
        int n, m, irq_last, dones;
        irq_last = -1;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk); rst_n = 1'b1;

        // Full transform with stray i_start pulses in RUN and WAIT.
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("t0_A", 32'(a), 0);
        chk("t0_B", 32'(b), 1);
        chk("t0_tw", 32'(tw), 0);
        chk("t0_busy", 32'(busy), 1);
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
            start = (n == 30 || n == 93);
            if (n == 1) begin
                chk("t1_A", 32'(a), 2); chk("t1_B", 32'(b), 3); chk("t1_tw", 32'(tw), 0);
            end
            if (n == 15) chk("t15_rd", 32'(rd_en), 1);
            if (n == 16) chk("t16_rd", 32'(rd_en), 0);
            if (n == 18) begin chk("t18_rd", 32'(rd_en), 0); chk("t18_wr", 32'(wr_en), 1); end
            if (n == 43) begin
                chk("s2j5_A", 32'(a), 9); chk("s2j5_B", 32'(b), 13);
                chk("s2j5_tw", 32'(tw), 4); chk("s2j5_stage", 32'(stage), 2);
            end
            if (n == 91) begin
                chk("s4j15_A", 32'(a), 15); chk("s4j15_B", 32'(b), 31);
                chk("s4j15_tw", 32'(tw), 15); chk("s4j15_stage", 32'(stage), 4);
            end
`ifdef FFT_AGU_STAGE_IRQ_EN
            if (stage_done) irq_last = n;
`endif
        end
        start = 1'b0;
        chk("done_edge", n, 95);
        chk("busy_in_done", 32'(busy), 0);
`ifdef FFT_AGU_STAGE_IRQ_EN
        chk("irq_last_edge", irq_last, 94);
`endif
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 0);

        // Abort mid-RUN with an asynchronous reset.
        repeat (2) @(posedge clk);
        #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #3; rst_n = 1'b0;
        #1; check_all_zero("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("no_done_after_abort", dones, 0);

        // Restart after abort.
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(200, n);
        chk("restart_done_edge", n, 95);

        // i_start held high: back-to-back transforms with one IDLE cycle.
        repeat (2) @(posedge clk);
        #1; start = 1'b1;
        @(posedge clk); #1;
        wait_done(200, n);
        chk("held_first_done", n, 95);
        m = 0;
        while (!rd_en && m < 10) begin
            @(posedge clk); #1;
            m++;
            if (m == 1) chk("held_idle_busy", 32'(busy), 0);
        end
        chk("held_restart_gap", m, 2);
        start = 1'b0;
        wait_done(200, n);
        chk("held_second_done", n, 95);
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

endmodule
